// File: rtl/sys_ctrl_pkg.sv
// Shared constants and types for the system command sequencer.
package sys_ctrl_pkg;

  // Frame opcodes (first byte of every command frame)
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file locations that hold the ALU operands
  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    RD_SEND,
    ALU_A,
    ALU_B,
    ALU_FUN,
    ALU_WAIT,
    SEND_LO,
    SEND_HI
  } state_e;

endpackage

// File: rtl/sys_ctrl.sv
// Command sequencer: decodes received byte frames into register-file
// accesses and ALU operations, and pushes response bytes to the TX FIFO.
// ALU_OUT_WIDTH is expected to be exactly 2*DATA_WIDTH (two response bytes).
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int FUN_WIDTH     = 4,
  parameter int ALU_OUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_valid,
  output logic [ADDR_WIDTH-1:0]    rf_addr,
  output logic                     rf_wr_en,
  output logic [DATA_WIDTH-1:0]    rf_wr_data,
  output logic                     rf_rd_en,
  input  logic [DATA_WIDTH-1:0]    rf_rd_data,
  input  logic                     rf_rd_valid,
  output logic                     alu_en,
  output logic [FUN_WIDTH-1:0]     alu_fun,
  input  logic [ALU_OUT_WIDTH-1:0] alu_out,
  input  logic                     alu_out_valid,
  output logic                     clk_gate_en,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     tx_wr_inc,
  input  logic                     fifo_full
);

  state_e                   state, state_next;
  logic [ALU_OUT_WIDTH-1:0] result, result_next;
  logic [ADDR_WIDTH-1:0]    rf_addr_next;
  logic                     rf_wr_en_next;
  logic [DATA_WIDTH-1:0]    rf_wr_data_next;
  logic                     rf_rd_en_next;
  logic                     alu_en_next;
  logic [FUN_WIDTH-1:0]     alu_fun_next;
  logic                     clk_gate_en_next;
  logic [DATA_WIDTH-1:0]    tx_data_next;
  logic                     tx_wr_inc_next;

  // State, response latch and every output are registered here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      result      <= '0;
      rf_addr     <= '0;
      rf_wr_en    <= 1'b0;
      rf_wr_data  <= '0;
      rf_rd_en    <= 1'b0;
      alu_en      <= 1'b0;
      alu_fun     <= '0;
      clk_gate_en <= 1'b0;
      tx_data     <= '0;
      tx_wr_inc   <= 1'b0;
    end else begin
      state       <= state_next;
      result      <= result_next;
      rf_addr     <= rf_addr_next;
      rf_wr_en    <= rf_wr_en_next;
      rf_wr_data  <= rf_wr_data_next;
      rf_rd_en    <= rf_rd_en_next;
      alu_en      <= alu_en_next;
      alu_fun     <= alu_fun_next;
      clk_gate_en <= clk_gate_en_next;
      tx_data     <= tx_data_next;
      tx_wr_inc   <= tx_wr_inc_next;
    end
  end

  // Frame decode: strobes default low, data outputs hold their last value
  always_comb begin
    state_next       = state;
    result_next      = result;
    rf_addr_next     = rf_addr;
    rf_wr_en_next    = 1'b0;
    rf_wr_data_next  = rf_wr_data;
    rf_rd_en_next    = 1'b0;
    alu_en_next      = 1'b0;
    alu_fun_next     = alu_fun;
    tx_data_next     = tx_data;
    tx_wr_inc_next   = 1'b0;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == DATA_WIDTH'(CMD_RF_WR))        state_next = WR_ADDR;
          else if (rx_data == DATA_WIDTH'(CMD_RF_RD))   state_next = RD_ADDR;
          else if (rx_data == DATA_WIDTH'(CMD_ALU_OP))  state_next = ALU_A;
          else if (rx_data == DATA_WIDTH'(CMD_ALU_NOP)) state_next = ALU_FUN;
        end
      end
      WR_ADDR: begin
        if (rx_valid) begin
          rf_addr_next = rx_data[ADDR_WIDTH-1:0];
          state_next   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rx_valid) begin
          rf_wr_en_next   = 1'b1;
          rf_wr_data_next = rx_data;
          state_next      = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_valid) begin
          rf_rd_en_next = 1'b1;
          rf_addr_next  = rx_data[ADDR_WIDTH-1:0];
          state_next    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rf_rd_valid) begin
          result_next = {{(ALU_OUT_WIDTH-DATA_WIDTH){1'b0}}, rf_rd_data};
          state_next  = RD_SEND;
        end
      end
      RD_SEND: begin
        if (!fifo_full) begin
          tx_wr_inc_next = 1'b1;
          tx_data_next   = result[DATA_WIDTH-1:0];
          state_next     = IDLE;
        end
      end
      ALU_A: begin
        if (rx_valid) begin
          rf_wr_en_next   = 1'b1;
          rf_addr_next    = ADDR_WIDTH'(OPA_ADDR);
          rf_wr_data_next = rx_data;
          state_next      = ALU_B;
        end
      end
      ALU_B: begin
        if (rx_valid) begin
          rf_wr_en_next   = 1'b1;
          rf_addr_next    = ADDR_WIDTH'(OPB_ADDR);
          rf_wr_data_next = rx_data;
          state_next      = ALU_FUN;
        end
      end
      ALU_FUN: begin
        if (rx_valid) begin
          alu_en_next  = 1'b1;
          alu_fun_next = rx_data[FUN_WIDTH-1:0];
          state_next   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (alu_out_valid) begin
          result_next = alu_out;
          state_next  = SEND_LO;
        end
      end
      SEND_LO: begin
        if (!fifo_full) begin
          tx_wr_inc_next = 1'b1;
          tx_data_next   = result[DATA_WIDTH-1:0];
          state_next     = SEND_HI;
        end
      end
      SEND_HI: begin
        if (!fifo_full) begin
          tx_wr_inc_next = 1'b1;
          tx_data_next   = result[2*DATA_WIDTH-1:DATA_WIDTH];
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Registered gate enable tracks the state being entered, so it is high
    // exactly during ALU_FUN and ALU_WAIT
    clk_gate_en_next = (state_next == ALU_FUN) || (state_next == ALU_WAIT);
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Self-checking bench for sys_ctrl: table-driven byte vectors plus
// hand-written multi-cycle sequences, with an event scoreboard.
module tb_sys_ctrl;
  import sys_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic [AW-1:0] rf_addr;
  logic          rf_wr_en;
  logic [DW-1:0] rf_wr_data;
  logic          rf_rd_en;
  logic [DW-1:0] rf_rd_data;
  logic          rf_rd_valid;
  logic          alu_en;
  logic [FW-1:0] alu_fun;
  logic [OW-1:0] alu_out;
  logic          alu_out_valid;
  logic          clk_gate_en;
  logic [DW-1:0] tx_data;
  logic          tx_wr_inc;
  logic          fifo_full;

  typedef enum logic [7:0] {EV_NONE, EV_WR, EV_RD, EV_ALU, EV_TX} ev_kind_e;

  typedef struct {
    ev_kind_e   kind;
    logic [7:0] a;
    logic [7:0] b;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    ev_kind_e   kind;
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  ev_t        exp_q[$];
  vec_t       vecs[10];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] exp_last_tx = 8'h00;
  logic       prev_wr = 1'b0;
  logic       prev_rd = 1'b0;
  logic       prev_alu = 1'b0;

  sys_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW), .ALU_OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
    .rf_rd_en(rf_rd_en), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .alu_en(alu_en), .alu_fun(alu_fun), .alu_out(alu_out),
    .alu_out_valid(alu_out_valid), .clk_gate_en(clk_gate_en),
    .tx_data(tx_data), .tx_wr_inc(tx_wr_inc), .fifo_full(fifo_full)
  );

  // 10-unit clock and a cycle counter used to time scoreboard events
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_push(input ev_kind_e kind, input logic [7:0] a, input logic [7:0] b, input int when);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.cyc = when;
    exp_q.push_back(e);
    if (kind == EV_TX) exp_last_tx = b;
  endtask

  task automatic sb_check(input ev_kind_e kind, input logic [7:0] a, input logic [7:0] b);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event: actual kind=%0d a=%0h b=%0h required none (cycle %0d)",
               kind, a, b, cyc);
    end else begin
      e = exp_q.pop_front();
      check_output("event", {8'h00, kind, a, b}, {8'h00, e.kind, e.a, e.b});
      if (e.cyc >= 0) check_output("event_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Monitor: every observed strobe/push is matched against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (rf_wr_en) begin
        check_output("wr_single_cycle", {31'h0, prev_wr}, 32'h0);
        sb_check(EV_WR, {4'h0, rf_addr}, rf_wr_data);
      end
      if (rf_rd_en) begin
        check_output("rd_single_cycle", {31'h0, prev_rd}, 32'h0);
        sb_check(EV_RD, {4'h0, rf_addr}, 8'h00);
      end
      if (alu_en) begin
        check_output("alu_single_cycle", {31'h0, prev_alu}, 32'h0);
        sb_check(EV_ALU, {4'h0, alu_fun}, 8'h00);
      end
      if (tx_wr_inc) sb_check(EV_TX, 8'h00, tx_data);
    end
    prev_wr  = rf_wr_en;
    prev_rd  = rf_rd_en;
    prev_alu = alu_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One received byte (one-cycle valid, one idle cycle after); any strobe
  // it produces is due in the following cycle
  task automatic apply_stimulus(input logic [7:0] data, input ev_kind_e kind,
                                input logic [7:0] a, input logic [7:0] b);
    rx_data  = data;
    rx_valid = 1'b1;
    if (kind != EV_NONE) sb_push(kind, a, b, cyc + 1);
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic pulse_rd(input logic [7:0] data);
    rf_rd_data  = data;
    rf_rd_valid = 1'b1;
    sb_push(EV_TX, 8'h00, data, cyc + 2);
    tick();
    rf_rd_valid = 1'b0;
  endtask

  task automatic pulse_alu(input logic [15:0] res, input bit expect_push);
    alu_out       = res;
    alu_out_valid = 1'b1;
    if (expect_push) begin
      sb_push(EV_TX, 8'h00, res[7:0], cyc + 2);
      sb_push(EV_TX, 8'h00, res[15:8], cyc + 3);
    end
    tick();
    alu_out_valid = 1'b0;
  endtask

  function automatic logic [31:0] all_outputs();
    return {3'b000, rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en,
            alu_fun, clk_gate_en, tx_data, tx_wr_inc};
  endfunction

  initial begin
    rx_data = 8'h00; rx_valid = 1'b0; rf_rd_data = 8'h00; rf_rd_valid = 1'b0;
    alu_out = 16'h0000; alu_out_valid = 1'b0; fifo_full = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    tick();
    check_output("reset_outputs", all_outputs(), 32'h0);
    #2 reset = 1'b1;
    tick();

    // Write frames, an ignored stray byte, and address upper-bit masking
    vecs[0] = '{8'hAA, EV_NONE, 8'h00, 8'h00};
    vecs[1] = '{8'h05, EV_NONE, 8'h00, 8'h00};
    vecs[2] = '{8'h3C, EV_WR,   8'h05, 8'h3C};
    vecs[3] = '{8'h77, EV_NONE, 8'h00, 8'h00};
    vecs[4] = '{8'hAA, EV_NONE, 8'h00, 8'h00};
    vecs[5] = '{8'h01, EV_NONE, 8'h00, 8'h00};
    vecs[6] = '{8'hFF, EV_WR,   8'h01, 8'hFF};
    vecs[7] = '{8'hAA, EV_NONE, 8'h00, 8'h00};
    vecs[8] = '{8'hF7, EV_NONE, 8'h00, 8'h00};
    vecs[9] = '{8'h81, EV_WR,   8'h07, 8'h81};
    for (int i = 0; i < 10; i++)
      apply_stimulus(vecs[i].data, vecs[i].kind, vecs[i].a, vecs[i].b);

    // Register read; a byte arriving during RD_WAIT is dropped
    apply_stimulus(8'hBB, EV_NONE, 8'h00, 8'h00);
    apply_stimulus(8'h05, EV_RD, 8'h05, 8'h00);
    apply_stimulus(8'hAA, EV_NONE, 8'h00, 8'h00);
    pulse_rd(8'h3C);
    repeat (3) tick();

    // Stray response strobes in IDLE are ignored
    alu_out = 16'hFFFF; alu_out_valid = 1'b1; rf_rd_valid = 1'b1; rf_rd_data = 8'h99;
    tick();
    alu_out_valid = 1'b0; rf_rd_valid = 1'b0;
    repeat (2) tick();

    // Full ALU operation with operand writes and clock gating
    apply_stimulus(8'hCC, EV_NONE, 8'h00, 8'h00);
    apply_stimulus(8'h0A, EV_WR, 8'h00, 8'h0A);
    check_output("gate_in_alu_b", {31'h0, clk_gate_en}, 32'h0);
    apply_stimulus(8'h03, EV_WR, 8'h01, 8'h03);
    check_output("gate_in_alu_fun", {31'h0, clk_gate_en}, 32'h1);
    apply_stimulus(8'h00, EV_ALU, 8'h00, 8'h00);
    check_output("gate_in_alu_wait", {31'h0, clk_gate_en}, 32'h1);
    apply_stimulus(8'hAA, EV_NONE, 8'h00, 8'h00);
    check_output("gate_after_drop", {31'h0, clk_gate_en}, 32'h1);
    pulse_alu(16'h000D, 1'b1);
    check_output("gate_in_send", {31'h0, clk_gate_en}, 32'h0);
    repeat (3) tick();

    // ALU NOP with the TX FIFO full at result time
    check_output("gate_idle", {31'h0, clk_gate_en}, 32'h0);
    apply_stimulus(8'hDD, EV_NONE, 8'h00, 8'h00);
    check_output("gate_nop_fun", {31'h0, clk_gate_en}, 32'h1);
    apply_stimulus(8'h02, EV_ALU, 8'h02, 8'h00);
    fifo_full = 1'b1;
    pulse_alu(16'hA55A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_output("hold_while_full", {23'h0, tx_wr_inc, tx_data}, {24'h0, exp_last_tx});
      tick();
    end
    fifo_full = 1'b0;
    sb_push(EV_TX, 8'h00, 8'h5A, cyc + 1);
    sb_push(EV_TX, 8'h00, 8'hA5, cyc + 2);
    repeat (4) tick();

    // Reset mid-frame abandons the frame and clears outputs at once
    apply_stimulus(8'hAA, EV_NONE, 8'h00, 8'h00);
    apply_stimulus(8'h01, EV_NONE, 8'h00, 8'h00);
    #3 reset = 1'b0;
    #1 check_output("async_reset_outputs", all_outputs(), 32'h0);
    #2 reset = 1'b1;
    tick();
    apply_stimulus(8'hFF, EV_NONE, 8'h00, 8'h00);
    apply_stimulus(8'hAA, EV_NONE, 8'h00, 8'h00);
    apply_stimulus(8'h02, EV_NONE, 8'h00, 8'h00);
    apply_stimulus(8'h11, EV_WR, 8'h02, 8'h11);
    repeat (4) tick();

    check_output("all_events_seen", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

Command sequencer between the receive-side synchronizer and the system datapath. It consumes byte frames delivered as one-cycle valid pulses from the RX-domain bus synchronizer and decodes them into register-file writes and reads and ALU operations. It gates the ALU clock and pushes response bytes into the TX async FIFO, honouring its full flag. Operates entirely in the reference (system) clock domain.

## Interface
- DATA_WIDTH, 8, command/data byte width
- ADDR_WIDTH, 4, register-file address width
- FUN_WIDTH, 4, ALU function code width
- ALU_OUT_WIDTH, 16, ALU result width; must equal 2*DATA_WIDTH
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_data  in  DATA_WIDTH  synchronized byte, valid only with rx_valid
- rx_valid  in  1  one-cycle strobe per received byte
- rf_addr  out  ADDR_WIDTH  register-file address
- rf_wr_en  out  1  one-cycle write strobe
- rf_wr_data  out  DATA_WIDTH  write data
- rf_rd_en  out  1  one-cycle read strobe
- rf_rd_data  in  DATA_WIDTH  read data, valid with rf_rd_valid
- rf_rd_valid  in  1  read-data strobe
- alu_en  out  1  one-cycle ALU start strobe
- alu_fun  out  FUN_WIDTH  ALU function code
- alu_out  in  ALU_OUT_WIDTH  ALU result, valid with alu_out_valid
- alu_out_valid  in  1  result strobe
- clk_gate_en  out  1  ALU clock-gate enable
- tx_data  out  DATA_WIDTH  byte to TX FIFO
- tx_wr_inc  out  1  one-cycle FIFO push
- fifo_full  in  1  TX FIFO full

## Operation
- Command opcodes (first byte of a frame): CMD_RF_WR=0xAA (addr, data), CMD_RF_RD=0xBB (addr), CMD_ALU_OP=0xCC (opA, opB, fun), CMD_ALU_NOP=0xDD (fun).
- All outputs are registered. Reset value of every output is 0; the FSM resets to IDLE.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, SEND_LO, SEND_HI.
- IDLE: on rx_valid, opcode 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->ALU_A, 0xDD->ALU_FUN. Any other byte is discarded and the FSM stays in IDLE.
- WR_ADDR: latch rx_data[ADDR_WIDTH-1:0] as the address. WR_DATA: on rx_valid, pulse rf_wr_en with the latched rf_addr and rf_wr_data=rx_data, then go to IDLE.
- RD_ADDR: on rx_valid, pulse rf_rd_en with rf_addr=rx_data[ADDR_WIDTH-1:0], then go to RD_WAIT. RD_WAIT: on rf_rd_valid, latch rf_rd_data and go to RD_SEND. RD_SEND: push once when fifo_full=0, then go to IDLE.
- ALU_A/ALU_B: on rx_valid, write the operand to register address 0 (A) or 1 (B) via an rf_wr_en pulse, then advance to ALU_B or ALU_FUN respectively.
- clk_gate_en is 1 in ALU_FUN and ALU_WAIT, and 0 in every other state.
- ALU_FUN: on rx_valid, pulse alu_en with alu_fun=rx_data[FUN_WIDTH-1:0] and go to ALU_WAIT. ALU_WAIT: on alu_out_valid, latch alu_out and go to SEND_LO.
- SEND_LO pushes alu_out[7:0]; SEND_HI pushes alu_out[15:8], then the FSM returns to IDLE. Each push waits for fifo_full=0.
- rx_valid while in RD_WAIT, ALU_WAIT or any SEND state is dropped; no buffering.
- Stray rf_rd_valid or alu_out_valid outside the matching wait state is ignored.
- No timeouts; the wait states hold indefinitely.

## Timing
- rx_valid in cycle n leads to the resulting strobe (rf_wr_en, rf_rd_en or alu_en) high for exactly cycle n+1.
- A push (tx_wr_inc high for one cycle with tx_data stable) is issued in the first cycle of a send state with fifo_full=0 sampled in the previous cycle.
- While fifo_full=1: tx_wr_inc=0, tx_data is held, and the state is held.
- Strobes never remain high for two consecutive cycles.
- Asynchronous reset asserted mid-frame clears all outputs immediately and returns the FSM to IDLE. A partial frame is abandoned.

## Structure
- Package sys_ctrl_pkg holds the opcode constants, the state enum, and the operand register addresses (OPA_ADDR=0, OPB_ADDR=1).
- Single module; no sub-module is needed.

## Test plan
- Frame 0xAA,0x05,0x3C -> one rf_wr_en pulse with rf_addr=5 and rf_wr_data=0x3C, one cycle after the third rx_valid; no TX push.
- Frame 0xBB,0x05, rf_rd_data=0x3C returned 2 cycles later -> one push with tx_data=0x3C; FSM back in IDLE.
- Frame 0xCC,0x0A,0x03,0x00 with alu_out=0x000D -> writes to addr 0 (0x0A) and addr 1 (0x03), then alu_en with alu_fun=0; clk_gate_en high from ALU_FUN through the result; pushes 0x0D then 0x00.
- Frame 0xDD,0x02 with fifo_full held high 5 cycles at result time -> no push while full; low byte pushed on the first cycle after release, high byte on the next cycle.
- Byte 0x77 in IDLE is ignored, then 0xAA,0x01,0xFF executes normally. Reset pulsed after 0xAA,0x01 -> all outputs 0 and IDLE; a following 0xFF is ignored.
